// File: rtl/panel_pkg.sv
// Shared port_o layout, widths and quadrature helpers for the front-panel input conditioner.
package panel_pkg;

  localparam int unsigned BTN_W     = 13;
  localparam int unsigned ENC_W     = 8;
  localparam int unsigned PORT_W    = 32;
  localparam int unsigned ENC_LINES = 4;
  localparam int unsigned BTN_LSB   = 0;
  localparam int unsigned ENC0_LSB  = 16;
  localparam int unsigned ENC1_LSB  = 24;

  typedef struct packed {
    logic a;
    logic b;
  } quad_t;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_INC,
    STEP_DEC,
    STEP_ERR
  } quad_step_e;

  // Position of {A,B} along the forward cycle 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] quad_phase(input quad_t q);
    return {q.b, q.a ^ q.b};
  endfunction

  function automatic quad_step_e quad_step(input quad_t prev, input quad_t cur);
    logic [1:0] delta;
    delta = quad_phase(cur) - quad_phase(prev);
    case (delta)
      2'd1:    return STEP_INC;
      2'd2:    return STEP_ERR;
      2'd3:    return STEP_DEC;
      default: return STEP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/panel_debounce.sv
// One input line: 2-FF synchronizer followed by a CYCLES-long stability debouncer.
// accept_o_c flags the cycle whose clock edge will load a new stable value.
module panel_debounce #(
  parameter int unsigned CYCLES    = 4,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o,
  output logic accept_o_c
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= {2{RESET_VAL}};
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], raw_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any cycle that agrees with the stable value restarts the count.
  always_comb begin
    stable_d   = stable_q;
    cnt_d      = '0;
    accept_o_c = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d   = sync_q[1];
        accept_o_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/panel_input_conditioner.sv
// Front-panel conditioner: debounced buttons plus two quadrature counters packed into port_o.
// Define PANEL_ENC_FILTER_EN to debounce encoder A/B lines with ENC_FILTER_CYCLES before decode.
module panel_input_conditioner
  import panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 50000,
  parameter int unsigned ENC_FILTER_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BTN_W-1:0]  btn_i,
  input  logic              enc0_a,
  input  logic              enc0_b,
  input  logic              enc1_a,
  input  logic              enc1_b,
  output logic [PORT_W-1:0] port_o,
  output logic              changed,
  output logic [1:0]        enc_err
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (ENC_FILTER_CYCLES < 1) begin : g_bad_enc_filter
    $error("ENC_FILTER_CYCLES must be at least 1");
  end

  logic [BTN_W-1:0] btn_stable;
  logic [BTN_W-1:0] btn_accept_c;

  for (genvar g = 0; g < BTN_W; g++) begin : g_btn
    panel_debounce #(
      .CYCLES   (DEBOUNCE_CYCLES),
      .RESET_VAL(1'b1)
    ) u_db (
      .clk       (clk),
      .reset     (reset),
      .raw_i     (btn_i[g]),
      .stable_o  (btn_stable[g]),
      .accept_o_c(btn_accept_c[g])
    );
  end

  // Encoder lines: [0] enc0_a, [1] enc0_b, [2] enc1_a, [3] enc1_b.
  logic [ENC_LINES-1:0] enc_raw;
  logic [ENC_LINES-1:0] enc_line;

  assign enc_raw = {enc1_b, enc1_a, enc0_b, enc0_a};

`ifdef PANEL_ENC_FILTER_EN
  for (genvar g = 0; g < ENC_LINES; g++) begin : g_enc_filt
    panel_debounce #(
      .CYCLES   (ENC_FILTER_CYCLES),
      .RESET_VAL(1'b0)
    ) u_filt (
      .clk       (clk),
      .reset     (reset),
      .raw_i     (enc_raw[g]),
      .stable_o  (enc_line[g]),
      .accept_o_c()
    );
  end
`else
  logic [ENC_LINES-1:0] enc_meta_q, enc_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_meta_q <= '0;
      enc_sync_q <= '0;
    end else begin
      enc_meta_q <= enc_raw;
      enc_sync_q <= enc_meta_q;
    end
  end

  assign enc_line = enc_sync_q;
`endif

  quad_t [1:0]            enc_cur;
  quad_t [1:0]            enc_prev_q, enc_prev_d;
  logic  [1:0][ENC_W-1:0] enc_cnt_q, enc_cnt_d;
  logic  [1:0]            enc_err_q, enc_err_d;
  logic  [1:0]            enc_upd_c;
  logic                   changed_q, changed_d;

  assign enc_cur[0] = quad_t'({enc_line[0], enc_line[1]});
  assign enc_cur[1] = quad_t'({enc_line[2], enc_line[3]});

  // A double-line jump has no direction: hold the count and latch the error.
  always_comb begin
    enc_prev_d = enc_cur;
    enc_cnt_d  = enc_cnt_q;
    enc_err_d  = enc_err_q;
    enc_upd_c  = '0;
    for (int e = 0; e < 2; e++) begin
      case (quad_step(enc_prev_q[e], enc_cur[e]))
        STEP_INC: begin
          enc_cnt_d[e] = enc_cnt_q[e] + ENC_W'(1);
          enc_upd_c[e] = 1'b1;
        end
        STEP_DEC: begin
          enc_cnt_d[e] = enc_cnt_q[e] - ENC_W'(1);
          enc_upd_c[e] = 1'b1;
        end
        STEP_ERR: enc_err_d[e] = 1'b1;
        default:  ;
      endcase
    end
  end

  // Every accept or count step alters port_o, so their OR marks a new word.
  assign changed_d = (|btn_accept_c) | (|enc_upd_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enc_prev_q <= '0;
      enc_cnt_q  <= '0;
      enc_err_q  <= '0;
      changed_q  <= 1'b0;
    end else begin
      enc_prev_q <= enc_prev_d;
      enc_cnt_q  <= enc_cnt_d;
      enc_err_q  <= enc_err_d;
      changed_q  <= changed_d;
    end
  end

  assign port_o[BTN_LSB +: BTN_W]            = btn_stable;
  assign port_o[ENC0_LSB-1 : BTN_LSB+BTN_W]  = '0;
  assign port_o[ENC0_LSB +: ENC_W]           = enc_cnt_q[0];
  assign port_o[ENC1_LSB +: ENC_W]           = enc_cnt_q[1];
  assign changed                             = changed_q;
  assign enc_err                             = enc_err_q;

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Self-checking bench for panel_input_conditioner: vector table, corner sequences, random run vs model.
module tb_panel_input_conditioner;

  localparam int DEB = 4;
  localparam int FLT = 2;
`ifdef PANEL_ENC_FILTER_EN
  localparam int ENC_LAT = FLT + 3;
`else
  localparam int ENC_LAT = 3;
`endif

  logic        clk;
  logic        reset;
  logic [12:0] btn_v;
  logic [1:0]  e0_v;   // {A,B}
  logic [1:0]  e1_v;   // {A,B}
  logic [31:0] port_o;
  logic        changed;
  logic [1:0]  enc_err;

  int checks = 0;
  int errors = 0;

  panel_input_conditioner #(
    .DEBOUNCE_CYCLES  (DEB),
    .ENC_FILTER_CYCLES(FLT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_v),
    .enc0_a (e0_v[1]),
    .enc0_b (e0_v[0]),
    .enc1_a (e1_v[1]),
    .enc1_b (e1_v[0]),
    .port_o (port_o),
    .changed(changed),
    .enc_err(enc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [12:0] q_btn [$];
  logic [3:0]  q_enc [$];
  logic [12:0] m_stable;
  logic [31:0] m_bhist [13];
  int          m_bage  [13];
`ifdef PANEL_ENC_FILTER_EN
  logic [3:0]  m_filt;
  logic [31:0] m_fhist [4];
  int          m_fage  [4];
`endif
  logic [1:0]  m_prev [2];
  logic [7:0]  m_cnt  [2];
  logic [1:0]  m_err;
  logic [31:0] m_port;
  logic        m_changed;

  // Index along the forward sequence 00,10,11,01.
  function automatic int phase(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] fwd(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] bwd(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Accept when the last n samples all oppose the stable value and n samples passed since the last accept.
  function automatic logic win_flip(input logic [31:0] hist, input logic stable, input int age, input int n);
    logic [31:0] mask;
    mask = (32'd1 << n) - 32'd1;
    if (age < n) return 1'b0;
    return stable ? ((hist & mask) == 32'd0) : ((hist & mask) == mask);
  endfunction

  task automatic model_reset();
    q_btn = {13'h1FFF, 13'h1FFF};
    q_enc = {4'h0, 4'h0};
    m_stable = 13'h1FFF;
    for (int b = 0; b < 13; b++) begin m_bhist[b] = '1; m_bage[b] = 0; end
`ifdef PANEL_ENC_FILTER_EN
    m_filt = 4'h0;
    for (int l = 0; l < 4; l++) begin m_fhist[l] = '0; m_fage[l] = 0; end
`endif
    for (int e = 0; e < 2; e++) begin m_prev[e] = 2'b00; m_cnt[e] = 8'h00; end
    m_err = 2'b00;
    m_port = 32'h0000_1FFF;
    m_changed = 1'b0;
  endtask

  task automatic model_step(input logic [12:0] b, input logic [3:0] en);
    logic [12:0] bu;
    logic [3:0]  eu, cur4;
    logic [1:0]  ab;
    logic [31:0] np;
    int d;
    q_btn.push_back(b); bu = q_btn.pop_front();
    q_enc.push_back(en); eu = q_enc.pop_front();
`ifdef PANEL_ENC_FILTER_EN
    cur4 = m_filt;
    for (int l = 0; l < 4; l++) begin
      m_fhist[l] = {m_fhist[l][30:0], eu[l]};
      m_fage[l]++;
      if (win_flip(m_fhist[l], m_filt[l], m_fage[l], FLT)) begin
        m_filt[l] = ~m_filt[l];
        m_fage[l] = 0;
      end
    end
`else
    cur4 = eu;
`endif
    for (int e = 0; e < 2; e++) begin
      ab = {cur4[2*e], cur4[2*e+1]};
      d = (phase(ab) - phase(m_prev[e]) + 4) % 4;
      if (d == 1) m_cnt[e] = m_cnt[e] + 8'd1;
      else if (d == 3) m_cnt[e] = m_cnt[e] - 8'd1;
      else if (d == 2) m_err[e] = 1'b1;
      m_prev[e] = ab;
    end
    for (int i = 0; i < 13; i++) begin
      m_bhist[i] = {m_bhist[i][30:0], bu[i]};
      m_bage[i]++;
      if (win_flip(m_bhist[i], m_stable[i], m_bage[i], DEB)) begin
        m_stable[i] = ~m_stable[i];
        m_bage[i] = 0;
      end
    end
    np = {m_cnt[1], m_cnt[0], 3'b000, m_stable};
    m_changed = (np != m_port);
    m_port = np;
  endtask

  // One clock: advance model with the inputs seen at the edge, then compare #1 later.
  task automatic tick();
    @(posedge clk);
    model_step(btn_v, {e1_v[0], e1_v[1], e0_v[0], e0_v[1]});
    #1;
    check("model port_o", port_o, m_port);
    check("model changed", {31'd0, changed}, {31'd0, m_changed});
    check("model enc_err", {30'd0, enc_err}, {30'd0, m_err});
  endtask

  task automatic set_idle();
    btn_v = 13'h1FFF;
    e0_v  = 2'b00;
    e1_v  = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset port_o", port_o, 32'h0000_1FFF);
    check("reset changed", {31'd0, changed}, 32'd0);
    check("reset enc_err", {30'd0, enc_err}, 32'd0);
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [12:0] btn;
    logic [1:0]  e0;
    logic [1:0]  e1;
    logic [31:0] exp_port;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int hit, pulses, chg_hit, idx, r;

    reset = 1'b1;
    set_idle();

    vecs[0]  = '{13'h1FFF, 2'b00, 2'b00, 32'h0000_1FFF, 2'b00};
    vecs[1]  = '{13'h1FEF, 2'b00, 2'b00, 32'h0000_1FEF, 2'b00};
    vecs[2]  = '{13'h1FEF, 2'b10, 2'b00, 32'h0001_1FEF, 2'b00};
    vecs[3]  = '{13'h1FEF, 2'b11, 2'b00, 32'h0002_1FEF, 2'b00};
    vecs[4]  = '{13'h1FEF, 2'b01, 2'b00, 32'h0003_1FEF, 2'b00};
    vecs[5]  = '{13'h1FEF, 2'b00, 2'b00, 32'h0004_1FEF, 2'b00};
    vecs[6]  = '{13'h1FFF, 2'b01, 2'b00, 32'h0003_1FFF, 2'b00};
    vecs[7]  = '{13'h1FFF, 2'b11, 2'b00, 32'h0002_1FFF, 2'b00};
    vecs[8]  = '{13'h1FFF, 2'b10, 2'b00, 32'h0001_1FFF, 2'b00};
    vecs[9]  = '{13'h1FFF, 2'b00, 2'b00, 32'h0000_1FFF, 2'b00};
    vecs[10] = '{13'h1FFF, 2'b01, 2'b00, 32'h00FF_1FFF, 2'b00};
    vecs[11] = '{13'h1FFF, 2'b01, 2'b10, 32'h01FF_1FFF, 2'b00};
    vecs[12] = '{13'h103F, 2'b01, 2'b10, 32'h01FF_103F, 2'b00};
    vecs[13] = '{13'h103F, 2'b01, 2'b01, 32'h01FF_103F, 2'b10};
    vecs[14] = '{13'h1FFF, 2'b01, 2'b11, 32'h00FF_1FFF, 2'b10};
    vecs[15] = '{13'h1FFF, 2'b00, 2'b11, 32'h0000_1FFF, 2'b10};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      btn_v = vecs[i].btn;
      e0_v  = vecs[i].e0;
      e1_v  = vecs[i].e1;
      repeat (10) tick();
      check($sformatf("vec%0d port_o", i), port_o, vecs[i].exp_port);
      check($sformatf("vec%0d changed", i), {31'd0, changed}, 32'd0);
      check($sformatf("vec%0d enc_err", i), {30'd0, enc_err}, {30'd0, vecs[i].exp_err});
    end

    // ENT press: accepted on edge DEB+2 with a single changed pulse.
    do_reset();
    btn_v = 13'h1FEF;
    hit = -1; pulses = 0; chg_hit = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (changed) pulses++;
      if (port_o[4] == 1'b0 && hit < 0) begin hit = i; chg_hit = int'(changed); end
    end
    check("ent latency edges", hit, DEB + 2);
    check("ent changed at accept", chg_hit, 1);
    check("ent changed pulses", pulses, 1);

    // Glitch one cycle short of acceptance is swallowed.
    do_reset();
    btn_v = 13'h1FFE;
    pulses = 0;
    repeat (DEB - 1) begin tick(); if (changed) pulses++; end
    btn_v = 13'h1FFF;
    repeat (12) begin tick(); if (changed) pulses++; end
    check("short glitch pulses", pulses, 0);
    check("short glitch port_o", port_o, 32'h0000_1FFF);

    // A pulse of exactly DEB cycles is accepted and then released.
    do_reset();
    btn_v = 13'h1FFE;
    pulses = 0;
    repeat (DEB) begin tick(); if (changed) pulses++; end
    btn_v = 13'h1FFF;
    repeat (14) begin tick(); if (changed) pulses++; end
    check("exact pulse changed pulses", pulses, 2);

    // Encoder step latency.
    do_reset();
    e0_v = 2'b10;
    hit = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (port_o[23:16] == 8'h01 && hit < 0) hit = i;
    end
    check("enc0 latency edges", hit, ENC_LAT);

    // Reset in the middle of a debounce with count at 05.
    do_reset();
    repeat (5) begin
      e0_v = fwd(e0_v);
      repeat (8) tick();
    end
    check("pre-reset enc0 count", {24'd0, port_o[23:16]}, 32'h05);
    btn_v = 13'h1FFB;
    repeat (2) tick();
    #2;
    reset = 1'b1;
    #1;
    check("async reset port_o", port_o, 32'h0000_1FFF);
    check("async reset changed", {31'd0, changed}, 32'd0);
    model_reset();
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    pulses = 0;
    repeat (10) begin tick(); if (changed) pulses++; end
    check("post-reset changed pulses", pulses, 0);
    check("post-reset port_o", port_o, 32'h0000_1FFF);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idx = int'($urandom_range(0, 12));
        btn_v[idx] = ~btn_v[idx];
      end
      r = int'($urandom_range(0, 99));
      if (r < 25) e0_v = fwd(e0_v);
      else if (r < 45) e0_v = bwd(e0_v);
      else if (r < 46) e0_v = ~e0_v;
      r = int'($urandom_range(0, 99));
      if (r < 20) e1_v = fwd(e1_v);
      else if (r < 40) e1_v = bwd(e1_v);
      else if (r < 41) e1_v = ~e1_v;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
